// File: rtl/spi_master_ctrl.sv
// ============================================================================
// Module   : spi_master_ctrl
// Purpose  : Byte-lane SPI master (mode 0) with one-byte prefetch and pulsed
//            MISO response stream.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_master_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_last,
    output logic       busy,
    output logic       CS,
    output logic       SCLK,
    output logic [7:0] MOSI,
    input  logic [7:0] MISO
);

    localparam int c_max_a     = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int c_max_phase = (c_max_a > CS_HOLD) ? c_max_a : CS_HOLD;
    localparam int c_cnt_w     = $clog2(c_max_phase + 1);

    localparam logic [c_cnt_w-1:0] c_ld_div   = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_ld_setup = c_cnt_w'(CS_SETUP - 1);
    localparam logic [c_cnt_w-1:0] c_ld_hold  = c_cnt_w'(CS_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_cs;
    logic                 r_sclk;
    logic [7:0]           r_mosi;
    logic                 r_tx_ready;
    logic                 r_rx_valid;
    logic [7:0]           r_rx_data;
    logic                 r_rx_last;
    logic                 r_busy;
    logic                 r_cur_last;
    logic [7:0]           r_pf_data;
    logic                 r_pf_last;
    logic                 r_pf_full;
    logic                 r_cap_pend;
    logic [7:0]           r_cap_data;
    logic                 r_cap_last;

    logic w_hs;
    logic w_in_xfer;
    logic w_pf_full_n;
    logic w_cnt_zero;

    assign w_hs        = tx_valid & r_tx_ready;
    assign w_in_xfer   = (r_state == ST_SETUP) || (r_state == ST_LOW) || (r_state == ST_HIGH);
    assign w_pf_full_n = r_pf_full | w_hs;
    assign w_cnt_zero  = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_cs       <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 8'h00;
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_cur_last <= 1'b0;
            r_pf_data  <= 8'h00;
            r_pf_last  <= 1'b0;
            r_pf_full  <= 1'b0;
            r_cap_pend <= 1'b0;
            r_cap_data <= 8'h00;
            r_cap_last <= 1'b0;
        end else begin
            // MISO captured on the SCLK rising edge is published one cycle later
            r_cap_pend <= 1'b0;
            r_rx_valid <= r_cap_pend;
            r_rx_last  <= r_cap_pend & r_cap_last;
            if (r_cap_pend) begin
                r_rx_data <= r_cap_data;
            end

            if (!w_cnt_zero) begin
                r_cnt <= r_cnt - c_one;
            end

            if (w_hs && w_in_xfer) begin
                r_pf_data <= tx_data;
                r_pf_last <= tx_last;
                r_pf_full <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_state    <= ST_SETUP;
                        r_cnt      <= c_ld_setup;
                        r_cs       <= 1'b0;
                        r_mosi     <= tx_data;
                        r_cur_last <= tx_last;
                        r_busy     <= 1'b1;
                        r_tx_ready <= ~tx_last;
                    end else begin
                        r_tx_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    r_tx_ready <= ~w_pf_full_n & ~r_cur_last;
                    if (w_cnt_zero) begin
                        r_state <= ST_LOW;
                        r_cnt   <= c_ld_div;
                    end
                end
                ST_LOW: begin
                    r_tx_ready <= ~w_pf_full_n & ~r_cur_last;
                    if (w_cnt_zero) begin
                        r_state    <= ST_HIGH;
                        r_cnt      <= c_ld_div;
                        r_sclk     <= 1'b1;
                        r_cap_pend <= 1'b1;
                        r_cap_data <= MISO;
                        r_cap_last <= r_cur_last;
                    end
                end
                ST_HIGH: begin
                    r_tx_ready <= ~w_pf_full_n & ~r_cur_last;
                    if (w_cnt_zero) begin
                        r_sclk <= 1'b0;
                        if (r_cur_last) begin
                            r_state    <= ST_HOLD;
                            r_cnt      <= c_ld_hold;
                            r_tx_ready <= 1'b0;
                        end else if (r_pf_full) begin
                            r_state    <= ST_LOW;
                            r_cnt      <= c_ld_div;
                            r_mosi     <= r_pf_data;
                            r_cur_last <= r_pf_last;
                            r_pf_full  <= 1'b0;
                            r_tx_ready <= ~r_pf_last;
                        end else if (w_hs) begin
                            // byte arriving in the last HIGH cycle bypasses the prefetch slot
                            r_state    <= ST_LOW;
                            r_cnt      <= c_ld_div;
                            r_mosi     <= tx_data;
                            r_cur_last <= tx_last;
                            r_pf_full  <= 1'b0;
                            r_tx_ready <= ~tx_last;
                        end else begin
                            r_state    <= ST_WAIT;
                            r_cnt      <= '0;
                            r_tx_ready <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_hs) begin
                        r_state    <= ST_LOW;
                        r_cnt      <= c_ld_div;
                        r_mosi     <= tx_data;
                        r_cur_last <= tx_last;
                        r_tx_ready <= ~tx_last;
                    end else begin
                        r_tx_ready <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    r_tx_ready <= 1'b0;
                    if (w_cnt_zero) begin
                        r_state    <= ST_IDLE;
                        r_cnt      <= '0;
                        r_cs       <= 1'b1;
                        r_mosi     <= 8'h00;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign rx_last  = r_rx_last;
    assign busy     = r_busy;
    assign CS       = r_cs;
    assign SCLK     = r_sclk;
    assign MOSI     = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
// ============================================================================
// Module   : tb_spi_master_ctrl
// Purpose  : Directed self-checking bench for spi_master_ctrl (three configs).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic [7:0] tx_data = 8'h00;
    int         sel = 0;

    logic [2:0] d_ready, d_rxv, d_rxl, d_busy, d_cs, d_sclk;
    logic [7:0] d_rxd [3];
    logic [7:0] d_mosi [3];

    logic [7:0] miso_tbl [8];
    int         rise_tot = 0;
    int         rise_base = 0;
    int         w_idx;
    logic [7:0] miso;

    assign w_idx = rise_tot - rise_base;
    assign miso  = miso_tbl[w_idx[2:0]];

    always #5 clk = ~clk;

    spi_master_ctrl #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) u_dut0 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid && sel == 0), .tx_ready(d_ready[0]),
        .tx_data(tx_data), .tx_last(tx_last), .rx_valid(d_rxv[0]), .rx_data(d_rxd[0]),
        .rx_last(d_rxl[0]), .busy(d_busy[0]), .CS(d_cs[0]), .SCLK(d_sclk[0]),
        .MOSI(d_mosi[0]), .MISO(miso));

    spi_master_ctrl #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid && sel == 1), .tx_ready(d_ready[1]),
        .tx_data(tx_data), .tx_last(tx_last), .rx_valid(d_rxv[1]), .rx_data(d_rxd[1]),
        .rx_last(d_rxl[1]), .busy(d_busy[1]), .CS(d_cs[1]), .SCLK(d_sclk[1]),
        .MOSI(d_mosi[1]), .MISO(miso));

    spi_master_ctrl #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_dut2 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid && sel == 2), .tx_ready(d_ready[2]),
        .tx_data(tx_data), .tx_last(tx_last), .rx_valid(d_rxv[2]), .rx_data(d_rxd[2]),
        .rx_last(d_rxl[2]), .busy(d_busy[2]), .CS(d_cs[2]), .SCLK(d_sclk[2]),
        .MOSI(d_mosi[2]), .MISO(miso));

    logic       m_ready, m_rxv, m_rxl, m_busy, m_cs, m_sclk;
    logic [7:0] m_rxd, m_mosi;
    assign m_ready = d_ready[sel];
    assign m_rxv   = d_rxv[sel];
    assign m_rxl   = d_rxl[sel];
    assign m_busy  = d_busy[sel];
    assign m_cs    = d_cs[sel];
    assign m_sclk  = d_sclk[sel];
    assign m_rxd   = d_rxd[sel];
    assign m_mosi  = d_mosi[sel];

    // Bus monitor on the selected instance, sampled just after each rising edge
    logic [7:0] mosi_q [$];
    logic [7:0] rx_d_q [$];
    logic       rx_l_q [$];
    int         gap_q [$];
    int         cs_low_tot = 0;
    int         rdy_low_tot = 0;
    int         cs_hi_run = 0;
    logic       prev_sclk = 1'b0;
    logic       prev_cs = 1'b1;

    always @(posedge clk) begin
        #1;
        if (m_sclk && !prev_sclk) begin
            rise_tot = rise_tot + 1;
            mosi_q.push_back(m_mosi);
        end
        prev_sclk = m_sclk;
        if (m_cs) begin
            cs_hi_run = cs_hi_run + 1;
        end else begin
            cs_low_tot = cs_low_tot + 1;
            if (prev_cs) gap_q.push_back(cs_hi_run);
            cs_hi_run = 0;
            if (m_ready) rdy_low_tot = rdy_low_tot + 1;
        end
        prev_cs = m_cs;
        if (m_rxv) begin
            rx_d_q.push_back(m_rxd);
            rx_l_q.push_back(m_rxl);
        end
    end

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte and return on the falling edge after its handshake
    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        while (m_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_handshake", 32'(m_ready === 1'b1), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_sclk(input logic v, input string tag);
        int n = 0;
        while (m_sclk !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(m_sclk), 32'(v));
    endtask

    int         b_cs, b_rx, b_mo, b_gap, b_rdy, n;
    logic       wait_ok;
    logic [7:0] exp_b;

    initial begin
        for (int i = 0; i < 8; i++) miso_tbl[i] = 8'h00;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(m_cs), 32'd1);
        chk("rst_sclk", 32'(m_sclk), 32'd0);
        chk("rst_mosi", 32'(m_mosi), 32'h00);
        chk("rst_ready", 32'(m_ready), 32'd0);
        chk("rst_rxv", 32'(m_rxv), 32'd0);
        chk("rst_rxd", 32'(m_rxd), 32'h00);
        chk("rst_rxl", 32'(m_rxl), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(m_ready), 32'd1);

        // Single byte, CLK_DIV=2, CS_SETUP=CS_HOLD=1
        sel = 1;
        rise_base = rise_tot;
        miso_tbl[0] = 8'h3C;
        b_cs = cs_low_tot; b_rx = rx_d_q.size(); b_mo = mosi_q.size();
        send(8'hA5, 1'b1);
        repeat (15) @(negedge clk);
        chk("t1_cs_low", 32'(cs_low_tot - b_cs), 32'd6);
        chk("t1_rises", 32'(rise_tot - rise_base), 32'd1);
        chk("t1_mosi", 32'(mosi_q[b_mo]), 32'hA5);
        chk("t1_rx_cnt", 32'(rx_d_q.size() - b_rx), 32'd1);
        chk("t1_rx_data", 32'(rx_d_q[b_rx]), 32'h3C);
        chk("t1_rx_last", 32'(rx_l_q[b_rx]), 32'd1);
        chk("t1_busy", 32'(m_busy), 32'd0);

        // 3-byte back-to-back frame, CLK_DIV=4
        sel = 0;
        rise_base = rise_tot;
        miso_tbl[0] = 8'hC1; miso_tbl[1] = 8'hC2; miso_tbl[2] = 8'hC3;
        b_cs = cs_low_tot; b_rx = rx_d_q.size(); b_mo = mosi_q.size();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b1);
        chk("t2_busy", 32'(m_busy), 32'd1);
        repeat (40) @(negedge clk);
        chk("t2_cs_low", 32'(cs_low_tot - b_cs), 32'd28);
        chk("t2_rises", 32'(rise_tot - rise_base), 32'd3);
        chk("t2_rx_cnt", 32'(rx_d_q.size() - b_rx), 32'd3);
        for (int i = 0; i < 3; i++) begin
            exp_b = 8'(i + 1);
            chk("t2_mosi", 32'(mosi_q[b_mo + i]), 32'(exp_b));
            exp_b = 8'(8'hC1 + i);
            chk("t2_rx_data", 32'(rx_d_q[b_rx + i]), 32'(exp_b));
            chk("t2_rx_last", 32'(rx_l_q[b_rx + i]), 32'(i == 2));
        end

        // Underrun: second byte offered 10 cycles after the first HIGH ends
        rise_base = rise_tot;
        miso_tbl[0] = 8'hD1; miso_tbl[1] = 8'hD2;
        b_rx = rx_d_q.size(); b_mo = mosi_q.size();
        send(8'h11, 1'b0);
        wait_sclk(1'b1, "t3_first_high");
        wait_sclk(1'b0, "t3_first_fall");
        wait_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_ok = wait_ok && (m_sclk === 1'b0) && (m_cs === 1'b0) &&
                      (m_mosi === 8'h11) && (m_ready === 1'b1);
            if (k < 9) @(negedge clk);
        end
        chk("t3_wait_phase", 32'(wait_ok), 32'd1);
        tx_valid = 1'b1; tx_data = 8'h22; tx_last = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("t3_mosi_after_wait", 32'(m_mosi), 32'h22);
        n = 0;
        while (m_sclk !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("t3_low_len", 32'(n), 32'd4);
        repeat (30) @(negedge clk);
        chk("t3_rx_cnt", 32'(rx_d_q.size() - b_rx), 32'd2);
        chk("t3_rx0", 32'(rx_d_q[b_rx]), 32'hD1);
        chk("t3_rx1", 32'(rx_d_q[b_rx + 1]), 32'hD2);
        chk("t3_rx_last", 32'({rx_l_q[b_rx], rx_l_q[b_rx + 1]}), 32'b01);
        chk("t3_mosi_seq", 32'({mosi_q[b_mo], mosi_q[b_mo + 1]}), 32'h1122);

        // Reset in the second HIGH cycle of byte 2 of a 4-byte frame
        b_rx = rx_d_q.size();
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        tx_valid = 1'b1; tx_data = 8'hB3; tx_last = 1'b0;
        wait_sclk(1'b1, "t4_b1_high");
        wait_sclk(1'b0, "t4_b2_low");
        wait_sclk(1'b1, "t4_b2_high");
        @(negedge clk);
        rst = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        chk("t4_cs", 32'(m_cs), 32'd1);
        chk("t4_sclk", 32'(m_sclk), 32'd0);
        chk("t4_mosi", 32'(m_mosi), 32'h00);
        chk("t4_rxv", 32'(m_rxv), 32'd0);
        chk("t4_busy", 32'(m_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t4_ready_after_rst", 32'(m_ready), 32'd1);
        repeat (10) @(negedge clk);
        chk("t4_rx_cnt", 32'(rx_d_q.size() - b_rx), 32'd2);
        rise_base = rise_tot;
        miso_tbl[0] = 8'h96;
        send(8'h5A, 1'b1);
        repeat (30) @(negedge clk);
        chk("t4_new_rx_cnt", 32'(rx_d_q.size() - b_rx), 32'd3);
        chk("t4_new_rx_data", 32'(rx_d_q[b_rx + 2]), 32'h96);
        chk("t4_new_rx_last", 32'(rx_l_q[b_rx + 2]), 32'd1);
        chk("t4_new_mosi", 32'(mosi_q[mosi_q.size() - 1]), 32'h5A);
        chk("t4_new_busy", 32'(m_busy), 32'd0);

        // Two single-byte frames with tx_valid held high
        b_gap = gap_q.size(); b_rdy = rdy_low_tot; b_mo = mosi_q.size();
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b1);
        repeat (30) @(negedge clk);
        chk("t5_frames", 32'(gap_q.size() - b_gap), 32'd2);
        chk("t5_gap", 32'(gap_q[gap_q.size() - 1]), 32'd1);
        chk("t5_ready_cs_low", 32'(rdy_low_tot - b_rdy), 32'd0);
        chk("t5_mosi_seq", 32'({mosi_q[b_mo], mosi_q[b_mo + 1]}), 32'hAABB);

        // CLK_DIV=1, 8-byte streamed frame
        sel = 2;
        rise_base = rise_tot;
        for (int i = 0; i < 8; i++) miso_tbl[i] = 8'(8'h80 >> i);
        b_cs = cs_low_tot; b_rx = rx_d_q.size(); b_mo = mosi_q.size();
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i), (i == 7));
        repeat (20) @(negedge clk);
        chk("t6_cs_low", 32'(cs_low_tot - b_cs), 32'd18);
        chk("t6_rises", 32'(rise_tot - rise_base), 32'd8);
        chk("t6_rx_cnt", 32'(rx_d_q.size() - b_rx), 32'd8);
        for (int i = 0; i < 8; i++) begin
            exp_b = 8'(8'h10 + i);
            chk("t6_mosi", 32'(mosi_q[b_mo + i]), 32'(exp_b));
            exp_b = 8'(8'h80 >> i);
            chk("t6_rx_data", 32'(rx_d_q[b_rx + i]), 32'(exp_b));
            chk("t6_rx_last", 32'(rx_l_q[b_rx + i]), 32'(i == 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
